// File: rtl/capture_trig_ctrl.sv
// Trigger-and-capture sequencer: tracks an IIR baseline of one channel and
// records {phase, baseline} words into the snapshot BRAM after a downward excursion.
module capture_trig_ctrl #(
    parameter int DATA_W = 16,
    parameter int CH_W   = 8,
    parameter int ADDR_W = 10
) (
    input  logic                  user_clk,
    input  logic                  user_rst_n,
    input  logic [31:0]           cfg_ctrl,
    input  logic [CH_W-1:0]       cfg_ch,
    input  logic [DATA_W-1:0]     cfg_thresh,
    input  logic [31:0]           base_kq,
    input  logic [ADDR_W-1:0]     cfg_len,
    input  logic                  in_valid,
    input  logic [CH_W-1:0]       in_ch,
    input  logic [DATA_W-1:0]     in_data,
    output logic                  bram_we,
    output logic [ADDR_W-1:0]     bram_addr,
    output logic [2*DATA_W-1:0]   bram_din,
    output logic                  busy,
    output logic                  done,
    output logic [15:0]           trig_count,
    output logic [DATA_W-1:0]     baseline_out
);

    typedef enum logic [1:0] {IDLE, ARMED, CAPTURE, DONE} state_t;

    state_t                     state_q;
    logic                       arm_prev_q;
    logic signed [DATA_W+15:0]  acc_q;
    logic [ADDR_W-1:0]          addr_q;
    logic [ADDR_W-1:0]          len_q;
    logic [CH_W-1:0]            ch_q;
    logic [15:0]                trig_cnt_q;
    logic                       bram_we_q;
    logic [ADDR_W-1:0]          bram_addr_q;
    logic [2*DATA_W-1:0]        bram_din_q;
    logic                       busy_q;
    logic                       done_q;

    logic                       arm;
    logic                       force_trig;
    logic                       arm_rise;
    logic                       match_live;
    logic                       match_lat;
    logic [3:0]                 kq;
    logic [DATA_W-1:0]          baseline;
    logic signed [DATA_W+16:0]  delta_full;
    logic signed [DATA_W+16:0]  delta_shift;
    logic signed [DATA_W+15:0]  acc_d;
    logic signed [DATA_W:0]     diff;
    logic                       thresh_hit;
    logic                       unused_bits;

    assign unused_bits = ^{cfg_ctrl[31:2], base_kq[31:4]};

    assign arm        = cfg_ctrl[0];
    assign force_trig = cfg_ctrl[1];
    assign arm_rise   = arm & ~arm_prev_q;
    assign kq         = base_kq[3:0];
    assign match_live = in_valid && (in_ch == cfg_ch);
    assign match_lat  = in_valid && (in_ch == ch_q);
    assign baseline   = acc_q[DATA_W+15:16];

    // One extra bit keeps (sample<<16 - acc) from overflowing; the sum always fits back in acc.
    assign delta_full  = $signed({in_data[DATA_W-1], in_data, 16'b0}) - $signed({acc_q[DATA_W+15], acc_q});
    assign delta_shift = delta_full >>> kq;
    assign acc_d       = acc_q + delta_shift[DATA_W+15:0];

    assign diff       = $signed({baseline[DATA_W-1], baseline}) - $signed({in_data[DATA_W-1], in_data});
    assign thresh_hit = diff > $signed({1'b0, cfg_thresh});

    always_ff @(posedge user_clk or negedge user_rst_n) begin
        if (!user_rst_n) begin
            state_q     <= IDLE;
            arm_prev_q  <= 1'b0;
            acc_q       <= '0;
            addr_q      <= '0;
            len_q       <= '0;
            ch_q        <= '0;
            trig_cnt_q  <= '0;
            bram_we_q   <= 1'b0;
            bram_addr_q <= '0;
            bram_din_q  <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            arm_prev_q <= arm;
            bram_we_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (match_live) acc_q <= acc_d;
                    if (arm_rise) begin
                        state_q <= ARMED;
                        busy_q  <= 1'b1;
                    end
                end
                ARMED: begin
                    if (match_live) acc_q <= acc_d;
                    // Disarm wins over a trigger arriving in the same cycle.
                    if (!arm) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end else if (match_live && (thresh_hit || force_trig)) begin
                        bram_we_q   <= 1'b1;
                        bram_addr_q <= '0;
                        bram_din_q  <= {in_data, baseline};
                        if (trig_cnt_q != 16'hFFFF) trig_cnt_q <= trig_cnt_q + 16'd1;
                        len_q  <= cfg_len;
                        ch_q   <= cfg_ch;
                        addr_q <= ADDR_W'(1);
                        if (cfg_len == '0) begin
                            state_q <= DONE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= CAPTURE;
                        end
                    end
                end
                CAPTURE: begin
                    if (match_lat) begin
                        bram_we_q   <= 1'b1;
                        bram_addr_q <= addr_q;
                        bram_din_q  <= {in_data, baseline};
                        if (addr_q == len_q) begin
                            state_q <= DONE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            addr_q <= addr_q + 1'b1;
                        end
                    end
                end
                DONE: begin
                    if (arm_rise) begin
                        state_q <= ARMED;
                        busy_q  <= 1'b1;
                        done_q  <= 1'b0;
                        addr_q  <= '0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bram_we      = bram_we_q;
    assign bram_addr    = bram_addr_q;
    assign bram_din     = bram_din_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign trig_count   = trig_cnt_q;
    assign baseline_out = baseline;

endmodule

// File: tb/tb_capture_trig_ctrl.sv
// Bench for capture_trig_ctrl: directed scenarios plus random traffic, all
// checked every cycle against a behavioural model of baseline, trigger and record rules.
module tb_capture_trig_ctrl;

    logic        user_clk = 1'b0;
    logic        user_rst_n = 1'b0;
    logic [31:0] cfg_ctrl = '0;
    logic [7:0]  cfg_ch = '0;
    logic [15:0] cfg_thresh = '0;
    logic [31:0] base_kq = '0;
    logic [9:0]  cfg_len = '0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_ch = '0;
    logic [15:0] in_data = '0;
    logic        bram_we;
    logic [9:0]  bram_addr;
    logic [31:0] bram_din;
    logic        busy;
    logic        done;
    logic [15:0] trig_count;
    logic [15:0] baseline_out;

    capture_trig_ctrl dut (
        .user_clk    (user_clk),
        .user_rst_n  (user_rst_n),
        .cfg_ctrl    (cfg_ctrl),
        .cfg_ch      (cfg_ch),
        .cfg_thresh  (cfg_thresh),
        .base_kq     (base_kq),
        .cfg_len     (cfg_len),
        .in_valid    (in_valid),
        .in_ch       (in_ch),
        .in_data     (in_data),
        .bram_we     (bram_we),
        .bram_addr   (bram_addr),
        .bram_din    (bram_din),
        .busy        (busy),
        .done        (done),
        .trig_count  (trig_count),
        .baseline_out(baseline_out)
    );

    always #5 user_clk = ~user_clk;

    int n_checks = 0;
    int n_fail   = 0;
    int n_writes = 0;

    // Model state: the sequencer is "waiting" when none of the three flags is set.
    longint m_acc;
    bit     m_arm_prev, m_armed, m_capturing, m_finished;
    int     m_next_addr, m_len, m_ch, m_count;
    bit     e_we, e_busy, e_done;
    int     e_addr, e_count, e_base;
    logic [31:0] e_din;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int base_of(input longint a);
        return int'(a >>> 16);
    endfunction

    task automatic model_reset();
        m_acc = 0; m_arm_prev = 0; m_armed = 0; m_capturing = 0; m_finished = 0;
        m_next_addr = 0; m_len = 0; m_ch = 0; m_count = 0;
    endtask

    task automatic model_step();
        bit arm, frc, rise, hit, waiting;
        int watch, b_old, x, kq;
        arm  = cfg_ctrl[0];
        frc  = cfg_ctrl[1];
        rise = arm && !m_arm_prev;
        m_arm_prev = arm;
        kq    = int'(base_kq[3:0]);
        watch = (m_capturing || m_finished) ? m_ch : int'(cfg_ch);
        hit   = in_valid && (int'(in_ch) == watch);
        x     = int'($signed(in_data));
        b_old = base_of(m_acc);
        waiting = !m_armed && !m_capturing && !m_finished;
        e_we = 0;
        if (waiting || m_armed) begin
            if (hit) m_acc = m_acc + (((longint'(x) * 65536) - m_acc) >>> kq);
        end
        if (waiting) begin
            if (rise) m_armed = 1;
        end else if (m_armed) begin
            if (!arm) begin
                m_armed = 0;
            end else if (hit && ((b_old - x) > int'(cfg_thresh) || frc)) begin
                e_we = 1; e_addr = 0; e_din = {x[15:0], b_old[15:0]};
                if (m_count < 65535) m_count++;
                m_len = int'(cfg_len); m_ch = int'(cfg_ch); m_armed = 0;
                if (m_len == 0) m_finished = 1;
                else begin m_capturing = 1; m_next_addr = 1; end
            end
        end else if (m_capturing) begin
            if (hit) begin
                e_we = 1; e_addr = m_next_addr; e_din = {x[15:0], b_old[15:0]};
                if (m_next_addr == m_len) begin m_capturing = 0; m_finished = 1; end
                else m_next_addr++;
            end
        end else if (m_finished) begin
            if (rise) begin m_finished = 0; m_armed = 1; end
        end
        e_busy = m_armed || m_capturing;
        e_done = m_finished;
        e_count = m_count;
        e_base = base_of(m_acc);
    endtask

    // Inputs must already be set; advances one clock and compares every output.
    task automatic step();
        int b;
        model_step();
        @(posedge user_clk);
        #1;
        if (bram_we) n_writes++;
        check_val("bram_we", bram_we, e_we);
        if (e_we) begin
            check_val("bram_addr", bram_addr, e_addr);
            check_val("bram_din", bram_din, e_din);
        end
        check_val("busy", busy, e_busy);
        check_val("done", done, e_done);
        check_val("trig_count", trig_count, e_count);
        b = e_base;
        check_val("baseline", baseline_out, b[15:0]);
    endtask

    task automatic cyc(input bit v, input int ch, input int data);
        in_valid = v;
        in_ch    = 8'(ch);
        in_data  = 16'(data);
        step();
    endtask

    task automatic apply_reset(input string tag);
        user_rst_n = 1'b0;
        #2;
        check_val({tag, "_we"}, bram_we, 0);
        check_val({tag, "_addr"}, bram_addr, 0);
        check_val({tag, "_din"}, bram_din, 0);
        check_val({tag, "_busy"}, busy, 0);
        check_val({tag, "_done"}, done, 0);
        check_val({tag, "_cnt"}, trig_count, 0);
        check_val({tag, "_base"}, baseline_out, 0);
        model_reset();
        @(negedge user_clk);
        user_rst_n = 1'b1;
    endtask

    initial begin
        int w0;
        model_reset();
        #12;
        apply_reset("rst0");

        // Convergence with kq = 2 on channel 5
        base_kq = 2; cfg_ch = 5; cfg_ctrl = 0;
        for (int i = 0; i < 64; i++) begin
            cyc(1, 5, 1000);
            check_val("no_overshoot", $signed(baseline_out) <= 1000, 1);
        end
        check_val("converge", $signed(baseline_out) >= 999, 1);

        // Threshold trigger: 950 holds, 899 fires with baseline 1000
        base_kq = 0; cfg_thresh = 100; cfg_len = 0;
        cyc(1, 5, 1000);
        cfg_ctrl = 1;
        cyc(0, 5, 0);
        base_kq = 15;
        cyc(1, 5, 950);
        check_val("t2_no_trig", bram_we, 0);
        base_kq = 0;
        cyc(1, 5, 1000);
        cyc(1, 5, 899);
        check_val("t2_trig_din", bram_din, {16'd899, 16'd1000});
        check_val("t2_trig_cnt", trig_count, 1);
        check_val("t2_done_len0", done, 1);

        // Forced record of 8 words with interleaved foreign channels
        cfg_ctrl = 0; cyc(0, 5, 0);
        cfg_ctrl = 3; cfg_len = 7; cyc(0, 5, 0);
        w0 = n_writes;
        for (int i = 0; i < 16; i++) cyc(1, (i % 2 == 0) ? 5 : 6, 200 + i);
        check_val("t3_writes", n_writes - w0, 8);
        check_val("t3_done", done, 1);

        // Disarm before trigger, then trigger-level sample on the disarm cycle
        cfg_ctrl = 0; cyc(0, 5, 0);
        cfg_ctrl = 1; w0 = n_writes;
        cyc(0, 5, 0);
        cyc(0, 5, 0);
        cfg_ctrl = 2;
        cyc(1, 5, -30000);
        cyc(0, 5, 0);
        check_val("t4_writes", n_writes - w0, 0);
        check_val("t4_busy", busy, 0);

        // Reset in the middle of a capture, then restart
        cfg_ctrl = 1; cyc(0, 5, 0);
        cfg_ctrl = 3; cfg_len = 7;
        for (int i = 0; i < 4; i++) cyc(1, 5, 10 * i);
        check_val("t5_addr3", bram_addr, 3);
        #2;
        apply_reset("t5_rst");
        cyc(0, 5, 0);
        cyc(1, 5, 77);
        check_val("t5_restart_addr", bram_addr, 0);

        // Held arm bit in DONE does not re-arm; a fresh edge does
        for (int i = 0; i < 7; i++) cyc(1, 5, 500 + i);
        for (int i = 0; i < 3; i++) cyc(1, 5, 0);
        check_val("t6_stay_done", done, 1);
        cfg_ctrl = 0; cyc(0, 5, 0);
        cfg_ctrl = 1; cyc(0, 5, 0);
        check_val("t6_rearm_done", done, 0);
        check_val("t6_rearm_busy", busy, 1);

        // Random traffic
        for (int n = 0; n < 3000; n++) begin
            int b;
            if ($urandom_range(0, 7) == 0) cfg_ctrl[0] = ~cfg_ctrl[0];
            if ($urandom_range(0, 15) == 0) cfg_ctrl[1] = ~cfg_ctrl[1];
            if ($urandom_range(0, 63) == 0) cfg_ch = 8'($urandom_range(0, 3));
            if ($urandom_range(0, 63) == 0) cfg_len = 10'($urandom_range(0, 12));
            if ($urandom_range(0, 63) == 0) base_kq = $urandom;
            if ($urandom_range(0, 31) == 0) cfg_thresh = 16'($urandom_range(0, 300));
            b = base_of(m_acc);
            if ($urandom_range(0, 9) == 0) cyc($urandom_range(0, 1) == 1, $urandom_range(0, 3), int'($urandom));
            else cyc($urandom_range(0, 3) != 0, $urandom_range(0, 3), b + int'($urandom_range(0, 500)) - 350);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
